// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multi-cycle control FSM for the single-issue MIPS core. It sequences
//   FETCH/DECODE/EXEC/MEM/WB around one shared instruction/data memory port,
//   produces the per-cycle datapath strobes, counts retired instructions,
//   flags illegal encodings and traps into ERROR on a memory-handshake
//   timeout.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode, funct       IR[31:26] and IR[5:0]
//   dec_memwrite        decoder store flag
//   dec_branch          decoder branch flag
//   dec_jump            decoder jump flag
//   alu_zero            ALU result is zero
//   mem_ready           memory completes the access this cycle
//   mem_req/sel/we      memory request, address select (0 PC, 1 ALU), write
//   ir_write            load IR from memory read data
//   pc_write, pc_src    PC load strobe and source (00 +4, 01 branch, 10 jump)
//   rf_we               register-file write strobe
//   retire, illegal     one-cycle pulses: completed / unsupported encoding
//   error               high while the FSM sits in ERROR
//   retired_cnt         wrapping count of retired instructions
//   state               IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERROR=6
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             dec_memwrite,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic             retire,
  output logic             illegal,
  output logic             error,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  logic [2:0]  next_state;
  logic [31:0] wait_cnt;
  logic        legal;
  logic        timeout_hit;

  // Supported encodings: four R-type functs plus addi, lw, sw, beq, j.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      6'h00:                             legal = funct inside {6'h20, 6'h21, 6'h22, 6'h24};
      6'h08, 6'h23, 6'h2B, 6'h04, 6'h02: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  // The current wait cycle would be the MEM_TIMEOUT-th one; zero disables it.
  assign timeout_hit = (MEM_TIMEOUT != 0) && ((wait_cnt + 32'd1) == 32'(MEM_TIMEOUT));

  // All outputs come from the current state (plus inputs) so a reset
  // drops an in-flight request immediately, without waiting for a clock.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    rf_we      = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end else if (timeout_hit) begin
          next_state = ERROR;
        end
      end
      DECODE: begin
        if (!legal) begin
          illegal    = 1'b1;
          next_state = FETCH;
        end else if (dec_jump) begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          retire     = 1'b1;
          next_state = FETCH;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (dec_branch) begin
          pc_write   = alu_zero;
          pc_src     = 2'b01;
          retire     = 1'b1;
          next_state = FETCH;
        end else if (opcode == 6'h23 || opcode == 6'h2B) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = dec_memwrite;
        if (mem_ready) begin
          retire     = dec_memwrite;
          next_state = dec_memwrite ? FETCH : WB;
        end else if (timeout_hit) begin
          next_state = ERROR;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      ERROR:   error = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  // State, retire counter and wait counter. The wait counter restarts on
  // every state change, which covers each entry into FETCH or MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      retired_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      state <= next_state;
      if (retire)
        retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (next_state != state)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Directed and randomized bench for the multi-cycle control FSM. For each
//   instruction the bench derives, from the instruction class and the chosen
//   memory wait counts, the expected per-cycle output trace and compares it
//   with the DUT mid-cycle.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        dec_memwrite = 1'b0;
  logic        dec_branch = 1'b0;
  logic        dec_jump = 1'b0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_sel, mem_we, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        rf_we, retire, illegal, error;
  logic [31:0] retired_cnt;
  logic [2:0]  state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;

  typedef struct packed {
    logic [2:0] st;
    logic       req, sel, we, irw, pcw;
    logic [1:0] src;
    logic       rfw, ret, ill, err;
  } exp_t;

  exp_t exp_q[$];
  logic rdy_q[$];

  mips_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .dec_memwrite(dec_memwrite), .dec_branch(dec_branch), .dec_jump(dec_jump),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_sel(mem_sel), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .rf_we(rf_we), .retire(retire),
    .illegal(illegal), .error(error), .retired_cnt(retired_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) return (fn == 6'h20 || fn == 6'h21 || fn == 6'h22 || fn == 6'h24);
    return (op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02);
  endfunction

  // Queue one expected cycle: state, outputs, and the mem_ready to drive.
  task automatic push(logic [2:0] st, logic req, logic sel, logic we, logic irw,
                      logic pcw, logic [1:0] src, logic rfw, logic ret,
                      logic ill, logic err, logic rdy);
    exp_t e;
    e = {st, req, sel, we, irw, pcw, src, rfw, ret, ill, err};
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Set decoder inputs for one instruction and build its expected trace.
  task automatic applyStimulus(logic [5:0] op, logic [5:0] fn, logic zero, int fw, int mw);
    logic st;
    opcode       = op;
    funct        = fn;
    dec_memwrite = (op == 6'h2B);
    dec_branch   = (op == 6'h04);
    dec_jump     = (op == 6'h02);
    alu_zero     = zero;
    st           = (op == 6'h2B);
    for (int i = 0; i < fw; i++) push(3'd1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    push(3'd1, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 1);
    if (!is_legal(op, fn)) begin
      push(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, rnd_bit());
    end else if (op == 6'h02) begin
      push(3'd2, 0, 0, 0, 0, 1, 2'b10, 0, 1, 0, 0, rnd_bit());
    end else begin
      push(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, rnd_bit());
      if (op == 6'h04) begin
        push(3'd3, 0, 0, 0, 0, zero, 2'b01, 0, 1, 0, 0, rnd_bit());
      end else if (op == 6'h23 || op == 6'h2B) begin
        push(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, rnd_bit());
        for (int i = 0; i < mw; i++) push(3'd4, 1, 1, st, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        push(3'd4, 1, 1, st, 0, 0, 2'b00, 0, st, 0, 0, 1);
        if (!st) push(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, rnd_bit());
      end else begin
        push(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, rnd_bit());
        push(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, rnd_bit());
      end
    end
  endtask

  // Play the expected trace: drive mem_ready after the edge, compare mid-cycle.
  task automatic checkOutput(string name);
    exp_t e, obs;
    int   cyc = 0;
    while (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      obs = {state, mem_req, mem_sel, mem_we, ir_write, pc_write, pc_src,
             rf_we, retire, illegal, error};
      check($sformatf("%s_c%0d_out", name, cyc), 32'(obs), 32'(e));
      check($sformatf("%s_c%0d_cnt", name, cyc), retired_cnt, exp_cnt);
      if (e.ret) exp_cnt++;
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  // Assert reset for one edge, check the all-zero reset image, release.
  task automatic doReset(string name);
    rst_n   = 1'b0;
    exp_cnt = '0;
    #1;
    check({name, "_rst_out"}, {18'd0, state, mem_req, mem_sel, mem_we, ir_write,
          pc_write, pc_src, rf_we, retire, illegal, error}, 32'd0);
    check({name, "_rst_cnt"}, retired_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, rnd_bit());
  endtask

  logic [5:0] ops[8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h10};
  logic [5:0] fns[6] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h2A, 6'h25};

  initial begin
    // Reset, then add with zero-wait memory.
    @(posedge clk);
    #1;
    doReset("t1");
    applyStimulus(6'h00, 6'h20, 0, 0, 0);
    checkOutput("t1_add");
    check("t1_count", retired_cnt, 32'd1);

    // lw with three MEM wait cycles.
    applyStimulus(6'h23, 6'h00, 0, 0, 3);
    checkOutput("t2_lw");

    // beq taken and not taken.
    applyStimulus(6'h04, 6'h00, 1, 0, 0);
    checkOutput("t3_beq_t");
    applyStimulus(6'h04, 6'h00, 0, 1, 0);
    checkOutput("t3_beq_nt");

    // Illegal opcode and illegal funct.
    applyStimulus(6'h3F, 6'h00, 0, 0, 0);
    checkOutput("t4_op3f");
    applyStimulus(6'h00, 6'h2A, 0, 0, 0);
    checkOutput("t4_fn2a");
    check("t4_state", 32'(state), 32'd1);

    // Randomized instruction stream with random wait states.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 5)], rnd_bit(),
                    $urandom_range(0, 3), $urandom_range(0, 5));
      checkOutput($sformatf("rnd%0d", n));
    end

    // Fetch timeout: mem_ready held low, ERROR after 15 wait cycles.
    for (int i = 0; i < 15; i++) push(3'd1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)  push(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, rnd_bit());
    checkOutput("t5_timeout");

    // Reset mid-MEM of sw drops the request without a clock edge.
    doReset("t6");
    push(3'd1, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 1);
    push(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    push(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    opcode       = 6'h2B;
    funct        = 6'h00;
    dec_memwrite = 1'b1;
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    checkOutput("t6_sw");
    mem_ready = 1'b0;
    #2;
    check("t6_mem_active", {30'd0, mem_req, mem_we}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", {27'd0, state, mem_req, mem_we}, 32'd0);
    check("t6_cnt", retired_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cnt = '0;
    push(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    applyStimulus(6'h08, 6'h00, 0, 1, 0);
    checkOutput("t6_addi");
    check("t6_final_cnt", retired_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case something stalls the directed sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
